// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame sizes and 50 MHz timing defaults.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SEND,
    ACK
  } ps2_tx_state_t;

  localparam int PS2_FRAME_BITS          = 11;
  localparam int PS2_TX_SHIFT_BITS       = 10;
  localparam int PS2_INHIBIT_CYCLES_50M  = 5000;
  localparam int PS2_TIMEOUT_CYCLES_50M  = 100000;

  // Serial order LSB first: d0..d7, odd parity, stop.
  function automatic logic [PS2_TX_SHIFT_BITS-1:0] ps2_tx_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_tx_timer.sv
// Loadable down-counter shared by the inhibit interval and the device clock timeout.
module ps2_tx_timer #(
  parameter int WIDTH = 17
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expired = (r_count == '0);

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 10 serial bits, then the device ACK bit.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_50M,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_50M
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       ps2_clk_negedge,
  input  logic       ps2_data,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int TIMER_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TW        = $clog2(TIMER_MAX + 1);
  localparam int BW        = $clog2(PS2_FRAME_BITS);

  ps2_tx_state_t               r_state;
  logic [PS2_TX_SHIFT_BITS-1:0] r_shreg;
  logic [BW-1:0]               r_bit_cnt;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_error;
  logic                        r_clk_oe;
  logic                        r_data_oe;

  logic                        w_load;
  logic [TW-1:0]               w_value;
  logic                        w_expired;
  logic                        w_accept;

  assign w_accept = (r_state == IDLE) && !r_busy && tx_start;

  // Entry to SEND loads the full timeout so the first negedge gets TIMEOUT_CYCLES+1 cycles;
  // each negedge reloads one less because the reload cycle itself already counts.
  always_comb begin
    w_load  = 1'b0;
    w_value = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_load  = 1'b1;
          w_value = TW'(INHIBIT_CYCLES - 1);
        end
      end
      START: begin
        w_load  = 1'b1;
        w_value = TW'(TIMEOUT_CYCLES);
      end
      SEND, ACK: begin
        if (ps2_clk_negedge) begin
          w_load  = 1'b1;
          w_value = TW'(TIMEOUT_CYCLES - 1);
        end
      end
      default: ;
    endcase
  end

  ps2_tx_timer #(
    .WIDTH (TW)
  ) u_timer (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .load    (w_load),
    .value   (w_value),
    .expired (w_expired)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          // busy stays up through the done cycle, so a start there is refused.
          r_busy    <= 1'b0;
          if (w_accept) begin
            r_shreg  <= ps2_tx_frame(tx_data);
            r_error  <= 1'b0;
            r_busy   <= 1'b1;
            r_clk_oe <= 1'b1;
            r_state  <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (w_expired) begin
            r_data_oe <= 1'b1;
            r_state   <= START;
          end
        end
        START: begin
          r_clk_oe  <= 1'b0;
          r_bit_cnt <= '0;
          r_state   <= SEND;
        end
        SEND: begin
          if (ps2_clk_negedge) begin
            r_data_oe <= ~r_shreg[0];
            r_shreg   <= {1'b0, r_shreg[PS2_TX_SHIFT_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == BW'(PS2_TX_SHIFT_BITS - 1)) begin
              r_state <= ACK;
            end
          end else if (w_expired) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_error   <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= IDLE;
          end
        end
        ACK: begin
          if (ps2_clk_negedge) begin
            r_error <= ps2_data;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else if (w_expired) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_error   <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed plus randomized bench for ps2_host_tx with a byte-level device and frame model.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 50;
  localparam int GAP = 3;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       ps2_clk_negedge = 1'b0;
  logic       ps2_data = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       busy, done, error, ps2_clk_oe, ps2_data_oe;

  int vectors = 0;
  int miscompares = 0;

  always #5 sys_clk = ~sys_clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .ps2_clk_negedge (ps2_clk_negedge),
    .ps2_data        (ps2_data),
    .tx_data         (tx_data),
    .tx_start        (tx_start),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .ps2_clk_oe      (ps2_clk_oe),
    .ps2_data_oe     (ps2_data_oe)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Expected data pull-low after each of the 10 negedges: inverse of d0..d7, odd parity, stop.
  function automatic logic [9:0] expected_oe(input int b);
    logic [9:0] oe;
    int ones;
    int bitv;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      bitv  = (b >> i) & 1;
      ones += bitv;
      oe[i] = (bitv == 0);
    end
    oe[8] = (ones % 2) != 0;
    oe[9] = 1'b0;
    return oe;
  endfunction

  task automatic start_tx(input logic [7:0] b);
    tx_data  = b;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    check("busy_after_start", busy, 1);
    check("clk_oe_inhibit_first", ps2_clk_oe, 1);
    check("data_oe_inhibit_first", ps2_data_oe, 0);
    repeat (INH - 1) tick();
    check("clk_oe_inhibit_last", ps2_clk_oe, 1);
    check("data_oe_inhibit_last", ps2_data_oe, 0);
    tick();
    check("clk_oe_start", ps2_clk_oe, 1);
    check("data_oe_start", ps2_data_oe, 1);
    tick();
    check("clk_oe_send_entry", ps2_clk_oe, 0);
    check("data_oe_send_entry", ps2_data_oe, 1);
  endtask

  task automatic send_edges(input logic [7:0] b, input int n, input logic ack, input int inject_at);
    logic [9:0] exp;
    exp = expected_oe(int'(b));
    for (int k = 1; k <= n; k++) begin
      for (int g = 0; g < GAP - 1; g++) begin
        if (k == inject_at && g == 0) begin
          tx_start = 1'b1;
          tx_data  = 8'h55;
        end
        tick();
        tx_start = 1'b0;
      end
      ps2_clk_negedge = 1'b1;
      if (k == 11) ps2_data = ack;
      tick();
      ps2_clk_negedge = 1'b0;
      ps2_data = 1'b1;
      if (k <= 10) begin
        check($sformatf("data_oe_b%02x_edge%0d", b, k), ps2_data_oe, exp[k-1]);
        check($sformatf("no_done_edge%0d", k), done, 0);
      end else begin
        check("done_after_ack", done, 1);
        check("error_after_ack", error, ack);
      end
    end
  endtask

  task automatic end_tx(input logic exp_err);
    tick();
    check("done_single_pulse", done, 0);
    check("busy_released", busy, 0);
    check("error_held", error, exp_err);
    check("clk_oe_idle", ps2_clk_oe, 0);
    check("data_oe_idle", ps2_data_oe, 0);
  endtask

  task automatic wait_done(input int c0, output int c);
    c = c0;
    while (!done && c < 200) begin
      tick();
      c++;
    end
  endtask

  initial begin
    int c;
    int seen;
    logic [7:0] rb;
    logic       ra;

    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    sys_rst = 1'b0;
    tick();

    // 0xED acknowledged
    start_tx(8'hED);
    send_edges(8'hED, 11, 1'b0, 0);
    end_tx(1'b0);

    // 0x00, device does not acknowledge
    start_tx(8'h00);
    send_edges(8'h00, 11, 1'b1, 0);
    end_tx(1'b1);

    // device stops after negedge 4
    start_tx(8'hA5);
    send_edges(8'hA5, 4, 1'b0, 0);
    wait_done(1, c);
    check("timeout_after_edge4_cycles", c, TMO + 1);
    check("timeout_error", error, 1);
    check("timeout_clk_oe", ps2_clk_oe, 0);
    check("timeout_data_oe", ps2_data_oe, 0);
    end_tx(1'b1);

    // device never clocks
    start_tx(8'h3C);
    wait_done(0, c);
    check("timeout_no_edge_cycles", c, TMO + 1);
    check("timeout_no_edge_error", error, 1);
    end_tx(1'b1);

    // second start mid-transfer is ignored
    start_tx(8'hFF);
    send_edges(8'hFF, 11, 1'b0, 5);
    end_tx(1'b0);

    // reset during SEND after negedge 6
    start_tx(8'h9A);
    send_edges(8'h9A, 6, 1'b0, 0);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_error", error, 0);
    check("midrst_clk_oe", ps2_clk_oe, 0);
    check("midrst_data_oe", ps2_data_oe, 0);
    seen = 0;
    repeat (10) begin
      tick();
      if (done) seen = 1;
    end
    check("midrst_no_done", seen, 0);
    start_tx(8'hF4);
    send_edges(8'hF4, 11, 1'b0, 0);

    // back-to-back: start in done cycle refused, next cycle accepted
    tx_data  = 8'h12;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    check("b2b_ignored_clk_oe", ps2_clk_oe, 0);
    check("b2b_ignored_busy", busy, 0);
    start_tx(8'hF4);
    send_edges(8'hF4, 11, 1'b0, 0);
    end_tx(1'b0);

    // randomized bytes and acknowledge values
    for (int t = 0; t < 4; t++) begin
      rb = 8'($urandom);
      ra = 1'($urandom_range(0, 1));
      start_tx(rb);
      send_edges(rb, 11, ra, 0);
      end_tx(ra);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
